// File: rtl/booth_sequential_multiplier_if.sv
// Start/ready handshake bundle for the Booth sequential multiplier.
//   start        : request, sampled on the rising clock edge while the multiplier is idle
//   multiplicand : signed operand M, sampled on the accepting edge
//   multiplier   : signed operand Q, sampled on the accepting edge
//   busy         : high while a multiplication is in flight
//   ready        : one-cycle pulse, product newly valid
//   product      : signed 2*WORD_LENGTH-bit result, held until the next completion
// The master modport belongs to the requester and the slave modport to the multiplier.
interface booth_sequential_multiplier_if #(
    parameter int unsigned WORD_LENGTH = 16
) ();
    logic                       start;
    logic [WORD_LENGTH-1:0]     multiplicand;
    logic [WORD_LENGTH-1:0]     multiplier;
    logic                       busy;
    logic                       ready;
    logic [2*WORD_LENGTH-1:0]   product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  ready,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output ready,
        output product
    );
endinterface

// File: rtl/booth_sequential_multiplier.sv
// Iterative radix-2 Booth multiplier. Each clock performs one add/subtract-and-shift step,
// so a product is ready WORD_LENGTH cycles after the start request is accepted.
//   clk   : system clock, rising-edge active
//   reset : asynchronous, active-high reset; aborts any operation in flight
//   bus   : start/operands/busy/ready/product handshake (slave side)
module booth_sequential_multiplier #(
    parameter int unsigned WORD_LENGTH = 16
) (
    input logic                          clk,
    input logic                          reset,
    booth_sequential_multiplier_if.slave bus
);
    localparam int unsigned CntW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q, state_d;
    // One guard bit on A keeps A - Mx exact when M is the most negative value.
    logic [WORD_LENGTH:0]     a_q, a_d;
    logic [WORD_LENGTH-1:0]   q_q, q_d;
    logic                     qm1_q, qm1_d;
    logic [WORD_LENGTH:0]     mx_q, mx_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [2*WORD_LENGTH-1:0] product_q, product_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;

    logic [WORD_LENGTH:0]     sum;
    logic [WORD_LENGTH:0]     a_sh;
    logic [WORD_LENGTH-1:0]   q_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            mx_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            mx_q      <= mx_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    // Booth recoding of the pair {Q[0], q_m1}, then arithmetic shift of {sum, Q, q_m1}.
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + mx_q;
            2'b10:   sum = a_q - mx_q;
            default: sum = a_q;
        endcase
        a_sh = {sum[WORD_LENGTH], sum[WORD_LENGTH:1]};
        q_sh = {sum[0], q_q[WORD_LENGTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        mx_d      = mx_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = '0;
                    q_d     = bus.multiplier;
                    qm1_d   = 1'b0;
                    mx_d    = {bus.multiplicand[WORD_LENGTH-1], bus.multiplicand};
                    cnt_d   = CntW'(WORD_LENGTH);
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = q_q[0];
                cnt_d = cnt_q - CntW'(1);
                // Last iteration: the shifted pair already holds the full product.
                if (cnt_q == CntW'(1)) begin
                    product_d = {a_sh[WORD_LENGTH-1:0], q_sh};
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Self-checking bench for booth_sequential_multiplier: directed corner cases, handshake
// timing, ignored starts, chained starts, async reset abort and random operands checked
// against plain integer multiplication.
module tb_booth_sequential_multiplier;
    localparam int unsigned W = 16;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    booth_sequential_multiplier_if #(.WORD_LENGTH(W)) bus ();

    booth_sequential_multiplier #(.WORD_LENGTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q);
        int sm;
        int sq;
        sm = int'($signed(m));
        sq = int'($signed(q));
        return 32'(sm * sq);
    endfunction

    // Issue one operation and watch it to completion. When interfere is set, a second
    // start with different operands is raised mid-flight and must be ignored.
    task automatic run_op(input logic [15:0] m, input logic [15:0] q, input bit interfere);
        int ready_edge;
        int pulses;
        int busy_cycles;
        int overlap;
        logic [31:0] exp;
        exp = ref_mul(m, q);
        ready_edge  = 0;
        pulses      = 0;
        busy_cycles = 0;
        overlap     = 0;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.multiplicand = ~m;
        bus.multiplier   = m ^ q;
        if (bus.busy) busy_cycles++;
        for (int e = 1; e <= int'(W) + 4; e++) begin
            if (interfere && e == 5) begin
                bus.start        = 1'b1;
                bus.multiplicand = 16'd9;
                bus.multiplier   = 16'd9;
            end
            if (interfere && e == 6) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.busy) busy_cycles++;
            if (bus.busy && bus.ready) overlap++;
            if (bus.ready) begin
                pulses++;
                if (ready_edge == 0) begin
                    ready_edge = e;
                    check_eq("product_at_ready", 64'(bus.product), 64'(exp));
                end
            end
        end
        check_eq("ready_latency", 64'(ready_edge), 64'(W));
        check_eq("ready_pulses", 64'(pulses), 64'd1);
        check_eq("busy_cycles", 64'(busy_cycles), 64'(W));
        check_eq("busy_ready_overlap", 64'(overlap), 64'd0);
        check_eq("product_held", 64'(bus.product), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        vectors     = 0;
        miscompares = 0;
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_ready", 64'(bus.ready), 64'd0);
        check_eq("reset_product", 64'(bus.product), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'd3, 16'd5, 1'b0);
        check_eq("const_3x5", 64'(bus.product), 64'h0000000F);
        run_op(16'hFFFD, 16'd5, 1'b0);
        check_eq("const_m3x5", 64'(bus.product), 64'hFFFFFFF1);
        run_op(16'd7, 16'hFFFF, 1'b0);
        check_eq("const_7xm1", 64'(bus.product), 64'hFFFFFFF9);
        run_op(16'h8000, 16'h8000, 1'b0);
        check_eq("const_min_min", 64'(bus.product), 64'h40000000);
        run_op(16'h8000, 16'h7FFF, 1'b0);
        check_eq("const_min_max", 64'(bus.product), 64'hC0008000);
        run_op(16'h7FFF, 16'h7FFF, 1'b0);
        check_eq("const_max_max", 64'(bus.product), 64'h3FFF0001);
        run_op(16'h0000, 16'h1234, 1'b0);
        check_eq("const_zero", 64'(bus.product), 64'h00000000);

        // Start raised while busy must not disturb the 2x3 operation.
        run_op(16'd2, 16'd3, 1'b1);
        check_eq("ignored_start", 64'(bus.product), 64'h00000006);

        // start held high: 4x4 then 2x2 chained with a 17-cycle pitch.
        pulses = 0;
        bus.multiplicand = 16'd4;
        bus.multiplier   = 16'd4;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.multiplicand = 16'd2;
        bus.multiplier   = 16'd2;
        for (int e = 1; e <= 36; e++) begin
            @(posedge clk);
            #1;
            if (e == 17) bus.start = 1'b0;
            if (bus.ready) pulses++;
            if (e == 16) check_eq("chain_ready_1", 64'(bus.ready), 64'd1);
            if (e == 16) check_eq("chain_product_1", 64'(bus.product), 64'h10);
            if (e == 25) check_eq("chain_stable", 64'(bus.product), 64'h10);
            if (e == 33) check_eq("chain_ready_2", 64'(bus.ready), 64'd1);
            if (e == 33) check_eq("chain_product_2", 64'(bus.product), 64'h4);
        end
        check_eq("chain_pulses", 64'(pulses), 64'd2);

        for (int i = 0; i < 24; i++) begin
            logic [15:0] m;
            logic [15:0] q;
            m = 16'($urandom);
            q = 16'($urandom);
            if (i % 6 == 0) m = 16'h8000;
            if (i % 8 == 1) q = 16'hFFFF;
            run_op(m, q, 1'b0);
        end
        run_op(16'd300, 16'hFF00, 1'b0);

        // Asynchronous reset in the middle of 100x100 aborts it.
        bus.multiplicand = 16'd100;
        bus.multiplier   = 16'd100;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_ready", 64'(bus.ready), 64'd0);
        check_eq("abort_product", 64'(bus.product), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.ready || bus.busy) pulses++;
        end
        check_eq("abort_no_activity", 64'(pulses), 64'd0);
        run_op(16'd10, 16'd10, 1'b0);
        check_eq("after_abort", 64'(bus.product), 64'h64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
